// File: rtl/softmax_argmax_terminator.sv
`default_nettype none
// ============================================================================
//  Module   : softmax_argmax_terminator
//  Purpose  : Clocked consumer of the asynchronous dual-rail softmax kernel.
//             Detects completion/spacer/illegal codes on the dual-rail
//             vector, synchronises them into the clk domain, captures the
//             true rail, finds the winning class by sequential argmax and
//             presents it on a valid/ready interface.
//  Ports    : clk, reset (async, active-low)
//             yt, yf       - dual-rail probability vector (class i at
//                            [BIT_SM*(i+1)-1 : BIT_SM*i])
//             ack_prev     - 4-phase acknowledge back to the softmax stage
//             class_idx    - winning class index
//             class_conf   - winning probability
//             early_term   - class_conf >= THRESH (build option)
//             dr_error     - sticky illegal dual-rail code seen
//             out_valid / out_ready - result handshake
//  Options  : `define EARLY_TERM_EN builds the threshold comparator;
//             otherwise early_term is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module softmax_argmax_terminator #(
    parameter int                KSIZE  = 10,
    parameter int                BIT_SM = 16,
    parameter logic [BIT_SM-1:0] THRESH = 16'd52429,
    parameter int                IDX_W  = $clog2(KSIZE)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [KSIZE*BIT_SM-1:0] yt,
    input  logic [KSIZE*BIT_SM-1:0] yf,
    output logic                    ack_prev,
    output logic [IDX_W-1:0]        class_idx,
    output logic [BIT_SM-1:0]       class_conf,
    output logic                    early_term,
    output logic                    dr_error,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [IDX_W-1:0] c_K_LAST = IDX_W'(KSIZE - 1);

    typedef enum logic [1:0] {
        S_WAIT_DATA = 2'd0,
        S_SCAN      = 2'd1,
        S_EMIT      = 2'd2,
        S_WAIT_NULL = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------
    // Dual-rail code detection (asynchronous inputs, combinational)
    // ------------------------------------------------------------------
    logic w_complete;
    logic w_null;
    logic w_illegal;

    assign w_complete = &(yt ^ yf);
    assign w_null     = ~|(yt | yf);
    assign w_illegal  = |(yt & yf);

    // Each detector gets its own 2-flop synchroniser. Complete and null
    // are mutually exclusive at the source and travel through identical
    // pipelines, so they can never both read as 1 in the same cycle.
    logic [1:0] r_cmp_sync;
    logic [1:0] r_null_sync;
    logic [1:0] r_ill_sync;
    logic       w_complete_s;
    logic       w_null_s;
    logic       w_illegal_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmp_sync  <= 2'b00;
            r_null_sync <= 2'b00;
            r_ill_sync  <= 2'b00;
        end else begin
            r_cmp_sync  <= {r_cmp_sync[0],  w_complete};
            r_null_sync <= {r_null_sync[0], w_null};
            r_ill_sync  <= {r_ill_sync[0],  w_illegal};
        end
    end

    assign w_complete_s = r_cmp_sync[1];
    assign w_null_s     = r_null_sync[1];
    assign w_illegal_s  = r_ill_sync[1];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] r_k;
    logic             w_capture;
    logic             w_scan_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_WAIT_DATA;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_scan_done  = 1'b0;
        case (r_state)
            S_WAIT_DATA: begin
                // Upstream holds the data stable until ack_prev rises.
                if (w_complete_s) begin
                    w_capture    = 1'b1;
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_k == c_K_LAST) begin
                    w_scan_done  = 1'b1;
                    w_state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_state_next = S_WAIT_NULL;
                end
            end
            S_WAIT_NULL: begin
                if (w_null_s) begin
                    w_state_next = S_WAIT_DATA;
                end
            end
            default: w_state_next = S_WAIT_DATA;
        endcase
    end

    // Acknowledge is high from the first scan cycle until the spacer has
    // been seen, which keeps the upstream stage from presenting new data.
    assign ack_prev  = (r_state != S_WAIT_DATA);
    assign out_valid = (r_state == S_EMIT);

    // ------------------------------------------------------------------
    // Capture register and sequential argmax
    // ------------------------------------------------------------------
    logic [BIT_SM-1:0] r_data [KSIZE];
    logic [BIT_SM-1:0] r_max;
    logic [IDX_W-1:0]  r_idx;
    logic [BIT_SM-1:0] w_cur;
    logic              w_take;
    logic [BIT_SM-1:0] w_max_next;
    logic [IDX_W-1:0]  w_idx_next;

    assign w_cur      = r_data[r_k];
    // Strict greater-than keeps the lowest index on ties; k=0 seeds.
    assign w_take     = (r_k == '0) || (w_cur > r_max);
    assign w_max_next = w_take ? w_cur : r_max;
    assign w_idx_next = w_take ? r_k   : r_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < KSIZE; i++) begin
                r_data[i] <= '0;
            end
            r_k        <= '0;
            r_max      <= '0;
            r_idx      <= '0;
            class_idx  <= '0;
            class_conf <= '0;
        end else begin
            if (w_capture) begin
                for (int i = 0; i < KSIZE; i++) begin
                    r_data[i] <= yt[i*BIT_SM +: BIT_SM];
                end
                r_k <= '0;
            end else if (r_state == S_SCAN) begin
                r_max <= w_max_next;
                r_idx <= w_idx_next;
                r_k   <= w_scan_done ? '0 : r_k + 1'b1;
            end
            // Result registers include the final class comparison so they
            // are valid on the same edge that enters S_EMIT.
            if (w_scan_done) begin
                class_idx  <= w_idx_next;
                class_conf <= w_max_next;
            end
        end
    end

`ifdef EARLY_TERM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            early_term <= 1'b0;
        end else if (w_scan_done) begin
            early_term <= (w_max_next >= THRESH);
        end
    end
`else
    // No comparator: the AND with 0 folds to a constant; THRESH is only
    // referenced so both builds keep an identical, fully-used interface.
    assign early_term = 1'b0 & (|THRESH);
`endif

    // ------------------------------------------------------------------
    // Sticky dual-rail error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dr_error <= 1'b0;
        end else if (w_illegal_s) begin
            dr_error <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_softmax_argmax_terminator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_softmax_argmax_terminator
//  Purpose  : Self-checking bench for softmax_argmax_terminator (KSIZE=4,
//             BIT_SM=16). Directed and randomised vectors are compared
//             against a plain argmax reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_softmax_argmax_terminator;

    localparam int K  = 4;
    localparam int W  = 16;
    localparam int IW = 2;
    localparam logic [W-1:0] c_THRESH = 16'd52429;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [K*W-1:0]    yt = '0;
    logic [K*W-1:0]    yf = '0;
    logic              out_ready = 1'b0;
    logic              ack_prev;
    logic [IW-1:0]     class_idx;
    logic [W-1:0]      class_conf;
    logic              early_term;
    logic              dr_error;
    logic              out_valid;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic exp_dr   = 1'b0;

    softmax_argmax_terminator #(
        .KSIZE  (K),
        .BIT_SM (W),
        .THRESH (c_THRESH)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .yt         (yt),
        .yf         (yf),
        .ack_prev   (ack_prev),
        .class_idx  (class_idx),
        .class_conf (class_conf),
        .early_term (early_term),
        .dr_error   (dr_error),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: first index holding the maximum value.
    function automatic int model_idx(input logic [K*W-1:0] v);
        int best = 0;
        for (int i = 1; i < K; i++)
            if (v[i*W +: W] > v[best*W +: W]) best = i;
        return best;
    endfunction

    function automatic logic [W-1:0] model_conf(input logic [K*W-1:0] v);
        int b = model_idx(v);
        return v[b*W +: W];
    endfunction

    function automatic logic model_et(input logic [K*W-1:0] v);
`ifdef EARLY_TERM_EN
        return model_conf(v) >= c_THRESH;
`else
        return (v == v) ? 1'b0 : 1'b0;
`endif
    endfunction

    // Drive and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input logic [K*W-1:0] v, input int hold,
                           input bit null_in_hold, input string tag);
        int          n;
        logic [31:0] ei, ec, ee;
        ei = model_idx(v);
        ec = 32'(model_conf(v));
        ee = 32'(model_et(v));
        out_ready = (hold == 0);
        yt = v;
        yf = ~v;
        n = 0;
        do begin step(); n++; end while (!out_valid && n < 30);
        check({tag, " latency"}, n, 2 + K + 1);
        check({tag, " idx"}, class_idx, ei);
        check({tag, " conf"}, class_conf, ec);
        check({tag, " early_term"}, early_term, ee);
        check({tag, " ack_high"}, ack_prev, 1);
        check({tag, " dr_error"}, dr_error, exp_dr);
        if (hold > 0) begin
            for (int c = 0; c < hold; c++) begin
                if (null_in_hold && c == hold / 2) begin
                    yt = '0;
                    yf = '0;
                end
                step();
            end
            check({tag, " held_valid"}, out_valid, 1);
            check({tag, " held_ack"}, ack_prev, 1);
            check({tag, " held_idx"}, class_idx, ei);
            check({tag, " held_conf"}, class_conf, ec);
            out_ready = 1'b1;
        end
        step();
        check({tag, " valid_drop"}, out_valid, 0);
        out_ready = 1'b0;
        yt = '0;
        yf = '0;
        n = 0;
        while (ack_prev && n < 10) begin step(); n++; end
        check({tag, " ack_release"}, ack_prev, 0);
        check({tag, " ack_release_time"}, 32'(n <= 3), 1);
    endtask

    initial begin
        logic [K*W-1:0] v;
        int             hold;

        // Reset state
        step(); step();
        check("rst ack_prev", ack_prev, 0);
        check("rst out_valid", out_valid, 0);
        check("rst class_idx", class_idx, 0);
        check("rst class_conf", class_conf, 0);
        check("rst early_term", early_term, 0);
        check("rst dr_error", dr_error, 0);
        reset = 1'b1;
        step(); step(); step();

        // Directed cases
        run_vec({16'h1000, 16'h8000, 16'h2000, 16'h4000}, 2, 1'b0, "basic");
        run_vec({16'h1000, 16'h8000, 16'hE000, 16'h4000}, 0, 1'b0, "thresh_hi");
        run_vec({16'h4000, 16'h0100, 16'h0100, 16'h4000}, 1, 1'b0, "tie");
        run_vec({16'h0100, 16'hCCCD, 16'h0200, 16'h0300}, 0, 1'b0, "thresh_eq");
        run_vec({16'h0100, 16'hCCCC, 16'h0200, 16'h0300}, 0, 1'b0, "thresh_below");
        run_vec({16'h1000, 16'h2000, 16'h3000, 16'h7000}, 20, 1'b1, "backpressure");

        // Illegal dual-rail code on bit 5 of class 0: never completes
        v  = {16'h1111, 16'h2222, 16'h3333, 16'h4440};
        yt = v;
        yf = ~v;
        yt[5] = 1'b1;
        yf[5] = 1'b1;
        step(); step(); step();
        exp_dr = 1'b1;
        check("illegal dr_error", dr_error, exp_dr);
        check("illegal ack", ack_prev, 0);
        for (int c = 0; c < 10; c++) step();
        check("illegal no_capture_ack", ack_prev, 0);
        check("illegal no_valid", out_valid, 0);
        yt = '0;
        yf = '0;
        step(); step(); step();
        check("illegal sticky", dr_error, exp_dr);
        run_vec({16'h0010, 16'h0020, 16'h9000, 16'h0040}, 0, 1'b0, "after_illegal");

        // Reset during the scan at k=2
        yt = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
        yf = ~yt;
        for (int c = 0; c < 5; c++) step();
        reset = 1'b0;
        #1;
        exp_dr = 1'b0;
        check("midrst ack", ack_prev, 0);
        check("midrst valid", out_valid, 0);
        check("midrst idx", class_idx, 0);
        check("midrst conf", class_conf, 0);
        check("midrst early_term", early_term, 0);
        check("midrst dr_error", dr_error, 0);
        yt = '0;
        yf = '0;
        step(); step();
        reset = 1'b1;
        step(); step(); step();
        check("postrst ack", ack_prev, 0);
        run_vec({16'h0500, 16'h0600, 16'hF000, 16'h0400}, 1, 1'b0, "postrst");

        // Randomised vectors, some drawn from a small set to force ties
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < K; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 4))
                        0: v[i*W +: W] = 16'h4000;
                        1: v[i*W +: W] = 16'h0100;
                        2: v[i*W +: W] = 16'hCCCD;
                        3: v[i*W +: W] = 16'hCCCC;
                        default: v[i*W +: W] = 16'h0000;
                    endcase
                end else begin
                    v[i*W +: W] = 16'($urandom);
                end
            end
            hold = $urandom_range(0, 5);
            run_vec(v, hold, (hold > 1) && ($urandom_range(0, 1) == 1), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/softmax_argmax_terminator.md
Name: softmax_argmax_terminator

Overview:
- Clocked consumer directly downstream of the asynchronous dual-rail softmax kernel.
- Receives the DENSE_KSIZE-wide dual-rail probability vector (yt/yf) over a 4-phase return-to-zero handshake and synchronises completion into the clock domain.
- Finds the winning class by sequential argmax and flags early termination when the winning probability reaches a threshold.
- Presents the result on a valid/ready interface to the network control logic.

Parameters:
- KSIZE, 10, number of classes (matches DENSE_KSIZE); minimum 2.
- BIT_SM, 16, bits per class probability (matches BIT_SOFTMAX); unsigned.
- THRESH, 16'd52429, early-termination threshold (~0.8 in Q0.16).
- IDX_W, $clog2(KSIZE), width of the class index.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- yt  in  KSIZE*BIT_SM  true rail of the softmax output; class i occupies [BIT_SM*(i+1)-1 : BIT_SM*i].
- yf  in  KSIZE*BIT_SM  false rail, same packing.
- ack_prev  out  1  acknowledge to the softmax stage (drives its ack_nxt).
- class_idx  out  IDX_W  winning class.
- class_conf  out  BIT_SM  winning probability.
- early_term  out  1  class_conf >= THRESH.
- dr_error  out  1  sticky; some bit pair had yt=yf=1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
Reset (reset=0, asynchronous): all outputs are 0; FSM goes to S_WAIT_DATA; synchronisers, capture register, scan counter and running max are cleared. Reset asserted mid-operation aborts any scan or pending emit. Because ack_prev drops to 0, the upstream stage is released.

Completion detection (combinational):
- complete = every bit pair has yt XOR yf = 1.
- null = every bit of yt and yf is 0.
- illegal = any pair has yt AND yf = 1.
- Each of these passes through its own 2-flop synchroniser: complete_s, null_s, illegal_s.

FSM:
- S_WAIT_DATA: ack_prev=0. When complete_s=1, capture yt into data_q; the next state is S_SCAN. Capture is safe because the 4-phase protocol holds the data stable until ack_prev rises.
- S_SCAN:
  - ack_prev=1 from the first S_SCAN cycle.
  - Counter k runs 0..KSIZE-1, one class per cycle.
  - k=0 loads max=data_q[0] and idx=0.
  - For k>0, update only when data_q[k] > max (strict), so ties keep the lowest index.
  - After k=KSIZE-1 the next state is S_EMIT.
- S_EMIT: out_valid=1; class_idx, class_conf and early_term are stable and held. On out_valid & out_ready the next state is S_WAIT_NULL and out_valid drops the next cycle.
- S_WAIT_NULL: ack_prev stays 1 until null_s=1. Then ack_prev=0 and the next state is S_WAIT_DATA.

Handshake timing:
- A complete vector arriving while the FSM is in S_SCAN or S_EMIT cannot occur, since ack_prev stays high until the spacer phase.
- Latency: the first edge seeing complete=1 is edge 0. Capture happens at edge 2. out_valid rises after edge 2+KSIZE.

Outputs and errors:
- class_idx, class_conf and early_term update only on the S_SCAN to S_EMIT transition and hold their values until the next one.
- dr_error is set when illegal_s=1 in any state and is cleared only by reset. An illegal vector never satisfies complete, so the FSM keeps waiting.
- Back-pressure: out_ready=0 holds S_EMIT indefinitely, with ack_prev held at 1.
- out_ready=1 during S_SCAN has no effect.

Optional Feature:
EARLY_TERM_EN:
- Defined: early_term = (class_conf >= THRESH), registered with class_conf.
- Undefined: early_term is tied to 0, no comparator is built, and THRESH is ignored.

Test Plan:
1. KSIZE=4, BIT_SM=16; after a null spacer drive yt={16'h1000,16'h8000,16'h2000,16'h4000} (class3..0) with yf=~yt -> ack_prev rises within 3 cycles; out_valid after 2+4 edges; class_idx=2, class_conf=16'h8000, early_term=0.
2. Same setup with class1=16'hE000 and EARLY_TERM_EN defined -> class_idx=1, early_term=1. With the macro undefined -> early_term=0.
3. Tie: classes 0 and 3 both 16'h4000, others 16'h0100 -> class_idx=0.
4. Hold out_ready=0 for 20 cycles, then return yt/yf to 0 -> out_valid and ack_prev stay 1 and outputs are stable. Set out_ready=1 -> out_valid falls next cycle; ack_prev falls 2–3 cycles after null is seen.
5. Force bit 5 of class 0 with yt=yf=1 -> dr_error=1 after 2 cycles, no capture, ack_prev=0. Only reset clears dr_error.
6. Assert reset during S_SCAN at k=2 -> all outputs 0 immediately. After release with null inputs the FSM is in S_WAIT_DATA, and the next vector yields the correct result.
